// File: rtl/adxl345_pkg.sv
// Shared constants for the ADXL345 SPI responder: register map, reset values,
// FSM state encodings and command-byte bit positions.
package adxl345_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam logic [7:0] DEVID_RST       = 8'hE5;
    localparam logic [7:0] BW_RATE_RST_DEF = 8'h0A;
    localparam logic [7:0] POWER_CTL_RST   = 8'h00;
    localparam logic [7:0] DATA_FORMAT_RST = 8'h00;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CMD  = 2'd1;
    localparam logic [1:0] ST_RD   = 2'd2;
    localparam logic [1:0] ST_WR   = 2'd3;

    localparam int RW_BIT = 7;
    localparam int MB_BIT = 6;

    // Only these three registers accept writes; everything else is read-only.
    function automatic logic is_cfg_addr(input logic [5:0] a);
        return (a == ADDR_BW_RATE) || (a == ADDR_POWER_CTL) || (a == ADDR_DATA_FORMAT);
    endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// Two-flop synchronizer followed by a registered edge detector; level, rise
// and fall all appear three clk after the pin changes.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic sync1_reg;
    logic sync2_reg;
    logic level_reg;
    logic rise_reg;
    logic fall_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= RST_VAL;
            sync2_reg <= RST_VAL;
            level_reg <= RST_VAL;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            level_reg <= sync2_reg;
            rise_reg  <= sync2_reg & ~level_reg;
            fall_reg  <= ~sync2_reg & level_reg;
        end
    end

    assign level = level_reg;
    assign rise  = rise_reg;
    assign fall  = fall_reg;

endmodule

// File: rtl/adxl345_spi_responder.sv
// ADXL345-compatible SPI slave (mode 3) serving register reads/writes from clk.
// Define ADXL345_RESP_SNAPSHOT_EN to freeze axis data at frame start.
module adxl345_spi_responder
    import adxl345_pkg::*;
#(
    parameter logic [7:0] DEVID_VAL   = 8'hE5,
    parameter logic [7:0] BW_RATE_RST = 8'h0A
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        spi_clk,
    input  logic        CS,
    input  logic        MOSI,
    output logic        MISO,
    input  logic [15:0] axis_x,
    input  logic [15:0] axis_y,
    input  logic [15:0] axis_z,
    input  logic        sample_valid,
    output logic [7:0]  power_ctl,
    output logic [7:0]  bw_rate,
    output logic [7:0]  data_format,
    output logic        wr_strobe,
    output logic [5:0]  wr_addr,
    output logic        busy
);

    logic sclk_rise, sclk_fall, unused_sclk_level;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, unused_mosi_rise, unused_mosi_fall;

    spi_edge_sync #(.RST_VAL(1'b1)) u_sclk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (spi_clk),
        .level (unused_sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_edge_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (CS),
        .level (cs_level),
        .rise  (cs_rise),
        .fall  (cs_fall)
    );

    // MOSI goes through the same pipeline so its level lines up with sclk_rise.
    spi_edge_sync #(.RST_VAL(1'b0)) u_mosi_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (MOSI),
        .level (mosi_level),
        .rise  (unused_mosi_rise),
        .fall  (unused_mosi_fall)
    );

    logic [47:0] axis_bytes;
    logic [47:0] sample_bytes;

    assign axis_bytes = {axis_z, axis_y, axis_x};

    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_sample
            logic [7:0] live_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    live_reg <= 8'h00;
                end else if (sample_valid) begin
                    live_reg <= axis_bytes[gi*8 +: 8];
                end
            end

`ifdef ADXL345_RESP_SNAPSHOT_EN
            logic [7:0] snap_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    snap_reg <= 8'h00;
                end else if (cs_fall) begin
                    snap_reg <= live_reg;
                end
            end

            assign sample_bytes[gi*8 +: 8] = snap_reg;
`else
            assign sample_bytes[gi*8 +: 8] = live_reg;
`endif
        end
    endgenerate

    logic [1:0] state_reg;
    logic [2:0] bit_cnt_reg;
    logic [7:0] shift_reg;
    logic [5:0] addr_reg;
    logic       mb_reg;
    logic       miso_reg;
    logic [7:0] power_ctl_reg;
    logic [7:0] bw_rate_reg;
    logic [7:0] data_format_reg;
    logic       wr_strobe_reg;
    logic [5:0] wr_addr_reg;

    logic [7:0] shift_in;
    logic       byte_done;
    logic [5:0] load_addr;
    logic [7:0] rd_data;

    assign shift_in  = {shift_reg[6:0], mosi_level};
    assign byte_done = (bit_cnt_reg == 3'd7);

    // Address of the byte about to be loaded: the command's start address,
    // or the next address once a data byte completes.
    always_comb begin
        load_addr = addr_reg;
        if (state_reg == ST_CMD) begin
            load_addr = shift_in[5:0];
        end else if (mb_reg) begin
            load_addr = addr_reg + 6'd1;
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (load_addr)
            ADDR_DEVID:       rd_data = DEVID_VAL;
            ADDR_BW_RATE:     rd_data = bw_rate_reg;
            ADDR_POWER_CTL:   rd_data = power_ctl_reg;
            ADDR_DATA_FORMAT: rd_data = data_format_reg;
            ADDR_DATAX0:      rd_data = sample_bytes[7:0];
            ADDR_DATAX1:      rd_data = sample_bytes[15:8];
            ADDR_DATAY0:      rd_data = sample_bytes[23:16];
            ADDR_DATAY1:      rd_data = sample_bytes[31:24];
            ADDR_DATAZ0:      rd_data = sample_bytes[39:32];
            ADDR_DATAZ1:      rd_data = sample_bytes[47:40];
            default:          rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            bit_cnt_reg     <= 3'd0;
            shift_reg       <= 8'h00;
            addr_reg        <= 6'd0;
            mb_reg          <= 1'b0;
            miso_reg        <= 1'b0;
            power_ctl_reg   <= POWER_CTL_RST;
            bw_rate_reg     <= BW_RATE_RST;
            data_format_reg <= DATA_FORMAT_RST;
            wr_strobe_reg   <= 1'b0;
            wr_addr_reg     <= 6'd0;
        end else begin
            wr_strobe_reg <= 1'b0;
            if (cs_rise) begin
                // Abort whatever is in flight; a partial write byte is dropped.
                state_reg <= ST_IDLE;
                miso_reg  <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state_reg   <= ST_CMD;
                            bit_cnt_reg <= 3'd0;
                        end
                    end
                    ST_CMD: begin
                        if (sclk_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            shift_reg   <= shift_in;
                            if (byte_done) begin
                                addr_reg <= shift_in[5:0];
                                mb_reg   <= shift_in[MB_BIT];
                                if (shift_in[RW_BIT]) begin
                                    state_reg <= ST_RD;
                                    shift_reg <= rd_data;
                                end else begin
                                    state_reg <= ST_WR;
                                end
                            end
                        end
                    end
                    ST_RD: begin
                        if (sclk_fall) begin
                            miso_reg  <= shift_reg[7];
                            shift_reg <= {shift_reg[6:0], 1'b0};
                        end else if (sclk_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            if (byte_done) begin
                                addr_reg  <= load_addr;
                                shift_reg <= rd_data;
                            end
                        end
                    end
                    ST_WR: begin
                        if (sclk_rise) begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            shift_reg   <= shift_in;
                            if (byte_done) begin
                                if (is_cfg_addr(addr_reg)) begin
                                    wr_strobe_reg <= 1'b1;
                                    wr_addr_reg   <= addr_reg;
                                    case (addr_reg)
                                        ADDR_BW_RATE:   bw_rate_reg     <= shift_in;
                                        ADDR_POWER_CTL: power_ctl_reg   <= shift_in;
                                        default:        data_format_reg <= shift_in;
                                    endcase
                                end
                                addr_reg <= load_addr;
                            end
                        end
                    end
                    default: state_reg <= ST_IDLE;
                endcase
            end
        end
    end

    assign MISO        = miso_reg;
    assign power_ctl   = power_ctl_reg;
    assign bw_rate     = bw_rate_reg;
    assign data_format = data_format_reg;
    assign wr_strobe   = wr_strobe_reg;
    assign wr_addr     = wr_addr_reg;
    assign busy        = ~cs_level;

endmodule

// File: tb/tb_adxl345_spi_responder.sv
// Bench for adxl345_spi_responder: directed and random SPI frames checked
// against a register-level model of the ADXL345 map.
module tb_adxl345_spi_responder;

    localparam int HALF = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        spi_clk = 1'b1;
    logic        cs = 1'b1;
    logic        mosi = 1'b0;
    logic        miso;
    logic [15:0] axis_x = 16'h0, axis_y = 16'h0, axis_z = 16'h0;
    logic        sample_valid = 1'b0;
    logic [7:0]  power_ctl, bw_rate, data_format;
    logic        wr_strobe;
    logic [5:0]  wr_addr;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // Model state
    logic [7:0]  m_power = 8'h00;
    logic [7:0]  m_bw    = 8'h0A;
    logic [7:0]  m_fmt   = 8'h00;
    logic [5:0]  m_wr_addr = 6'h00;
    logic [47:0] m_samp  = 48'h0;
    int          strobe_cnt = 0;
    int          last_strobe_cyc = -100;
    bit          settled = 1'b0;
    logic [7:0]  wdata    [0:7];
    logic [7:0]  rd_bytes [0:7];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adxl345_spi_responder dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .spi_clk      (spi_clk),
        .CS           (cs),
        .MOSI         (mosi),
        .MISO         (miso),
        .axis_x       (axis_x),
        .axis_y       (axis_y),
        .axis_z       (axis_z),
        .sample_valid (sample_valid),
        .power_ctl    (power_ctl),
        .bw_rate      (bw_rate),
        .data_format  (data_format),
        .wr_strobe    (wr_strobe),
        .wr_addr      (wr_addr),
        .busy         (busy)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register map as seen by a reader; s holds {Z1,Z0,Y1,Y0,X1,X0}.
    function automatic logic [7:0] model_read(input logic [5:0] a, input logic [47:0] s);
        int idx;
        idx = int'(a) - 50;
        if (a == 6'h00) return 8'hE5;
        if (a == 6'h2C) return m_bw;
        if (a == 6'h2D) return m_power;
        if (a == 6'h31) return m_fmt;
        if (idx >= 0 && idx < 6) return s[idx*8 +: 8];
        return 8'h00;
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && wr_strobe === 1'b1) begin
                strobe_cnt++;
                last_strobe_cyc = cyc;
            end
            if (settled) begin
                chk("idle_power_ctl", 32'(power_ctl), 32'(m_power));
                chk("idle_bw_rate", 32'(bw_rate), 32'(m_bw));
                chk("idle_data_format", 32'(data_format), 32'(m_fmt));
                chk("idle_wr_addr", 32'(wr_addr), 32'(m_wr_addr));
                chk("idle_wr_strobe", 32'(wr_strobe), 32'd0);
                chk("idle_busy", 32'(busy), 32'd0);
                chk("idle_miso", 32'(miso), 32'd0);
            end
        end
    endtask

    task automatic load_samples(input logic [47:0] s);
        axis_x = s[15:0];
        axis_y = s[31:16];
        axis_z = s[47:32];
        sample_valid = 1'b1;
        @(negedge clk);
        sample_valid = 1'b0;
        m_samp = s;
    endtask

    // One SPI frame. abort_bits >= 0 raises CS after that many clocks;
    // fire_idx selects the data byte at whose start new samples arrive.
    task automatic frame(input logic [7:0] cmd, input int nbytes, input int abort_bits,
                         input int fire_idx, input logic [47:0] new_s);
        int total, bi, exp_str, commit_rise, rise_c;
        logic [5:0]  a;
        logic [7:0]  exp_b, got;
        logic [47:0] src;
        settled = 1'b0;
        exp_str = strobe_cnt;
        commit_rise = -1;
        exp_b = 8'h00;
        got = 8'h00;
        a = cmd[5:0];
        @(negedge clk);
        cs = 1'b0;
        src = m_samp;
        repeat (2) @(negedge clk);
        chk("busy_before_3clk", 32'(busy), 32'd0);
        @(negedge clk);
        chk("busy_at_3clk", 32'(busy), 32'd1);
        repeat (4) @(negedge clk);
        total = (abort_bits >= 0) ? abort_bits : 8 * (nbytes + 1);
        for (int b = 0; b < total; b++) begin
            bi = b / 8 - 1;
            if (b % 8 == 0 && bi >= 0 && bi == fire_idx) load_samples(new_s);
`ifndef ADXL345_RESP_SNAPSHOT_EN
            src = m_samp;
`endif
            spi_clk = 1'b0;
            mosi = (bi < 0) ? cmd[7 - b % 8] : wdata[bi][7 - b % 8];
            repeat (HALF) @(negedge clk);
            got[7 - b % 8] = miso;
            spi_clk = 1'b1;
            rise_c = cyc;
            repeat (HALF) @(negedge clk);
            if (b % 8 == 7) begin
                if (bi < 0) begin
                    exp_b = model_read(a, src);
                end else if (cmd[7]) begin
                    rd_bytes[bi] = got;
                    chk($sformatf("rd_byte%0d_addr%0h", bi, a), 32'(got), 32'(exp_b));
                    if (cmd[6]) a = a + 6'd1;
                    exp_b = model_read(a, src);
                end else begin
                    if (a == 6'h2C || a == 6'h2D || a == 6'h31) begin
                        if (a == 6'h2C) m_bw = wdata[bi];
                        else if (a == 6'h2D) m_power = wdata[bi];
                        else m_fmt = wdata[bi];
                        m_wr_addr = a;
                        exp_str++;
                        commit_rise = rise_c;
                    end
                    if (cmd[6]) a = a + 6'd1;
                end
            end
        end
        cs = 1'b1;
        repeat (2) @(negedge clk);
        chk("busy_hold_after_cs", 32'(busy), 32'd1);
        @(negedge clk);
        chk("busy_drop_3clk", 32'(busy), 32'd0);
        repeat (6) @(negedge clk);
        chk("strobe_count", 32'(strobe_cnt), 32'(exp_str));
        if (commit_rise >= 0)
            chk("strobe_latency", 32'(last_strobe_cyc - commit_rise), 32'd4);
        settled = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  lit [0:5];
        logic [5:0]  pick [0:8];
        logic [5:0]  ra;
        logic [47:0] ns;
        int          n, ab, fi;
        fork
            monitor();
        join_none

        repeat (4) @(negedge clk);
        chk("rst_miso", 32'(miso), 32'd0);
        chk("rst_power_ctl", 32'(power_ctl), 32'h00);
        chk("rst_bw_rate", 32'(bw_rate), 32'h0A);
        chk("rst_data_format", 32'(data_format), 32'h00);
        chk("rst_wr_strobe", 32'(wr_strobe), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        settled = 1'b1;
        repeat (4) @(negedge clk);

        // DEVID read
        frame(8'h80, 1, -1, -1, 48'h0);
        chk("lit_devid", 32'(rd_bytes[0]), 32'hE5);

        // POWER_CTL write
        wdata[0] = 8'h08;
        frame(8'h2D, 1, -1, -1, 48'h0);
        chk("lit_power_ctl", 32'(power_ctl), 32'h08);
        chk("lit_wr_addr", 32'(wr_addr), 32'h2D);

        // Six-byte axis burst
        settled = 1'b0;
        load_samples({16'h0100, 16'hFF80, 16'h1234});
        settled = 1'b1;
        frame(8'hF2, 6, -1, -1, 48'h0);
        lit = '{8'h34, 8'h12, 8'h80, 8'hFF, 8'h00, 8'h01};
        for (int i = 0; i < 6; i++) chk($sformatf("lit_axis_b%0d", i), 32'(rd_bytes[i]), 32'(lit[i]));

        // New samples arrive during byte 2 of the burst
        frame(8'hF2, 6, -1, 2, {16'h7788, 16'h5566, 16'hABCD});
`ifdef ADXL345_RESP_SNAPSHOT_EN
        lit = '{8'h34, 8'h12, 8'h80, 8'hFF, 8'h00, 8'h01};
`else
        lit = '{8'h34, 8'h12, 8'h80, 8'h55, 8'h88, 8'h77};
`endif
        for (int i = 0; i < 6; i++) chk($sformatf("lit_midframe_b%0d", i), 32'(rd_bytes[i]), 32'(lit[i]));

        // Aborted DATA_FORMAT write, then normal frames
        wdata[0] = 8'hFF;
        frame(8'h31, 1, 13, -1, 48'h0);
        chk("lit_abort_fmt", 32'(data_format), 32'h00);
        frame(8'hB1, 1, -1, -1, 48'h0);
        chk("lit_fmt_read", 32'(rd_bytes[0]), 32'h00);
        frame(8'h80, 1, -1, -1, 48'h0);
        chk("lit_devid_after_abort", 32'(rd_bytes[0]), 32'hE5);

        // Write to read-only DEVID
        wdata[0] = 8'h55;
        frame(8'h00, 1, -1, -1, 48'h0);
        frame(8'h80, 1, -1, -1, 48'h0);
        chk("lit_devid_ro", 32'(rd_bytes[0]), 32'hE5);

        // Address wrap 0x3F -> 0x00
        frame(8'hFF, 2, -1, -1, 48'h0);
        chk("lit_wrap_b0", 32'(rd_bytes[0]), 32'h00);
        chk("lit_wrap_b1", 32'(rd_bytes[1]), 32'hE5);

        // Multi-byte write across BW_RATE and POWER_CTL
        wdata[0] = 8'h0F;
        wdata[1] = 8'h28;
        frame(8'h6C, 2, -1, -1, 48'h0);
        chk("lit_mb_bw", 32'(bw_rate), 32'h0F);
        chk("lit_mb_power", 32'(power_ctl), 32'h28);

        // Random frames
        pick = '{6'h00, 6'h2C, 6'h2D, 6'h31, 6'h32, 6'h34, 6'h36, 6'h37, 6'h3F};
        for (int i = 0; i < 25; i++) begin
            ra = ($urandom_range(0, 3) == 0) ? 6'($urandom) : pick[$urandom_range(0, 8)];
            n = $urandom_range(1, 3);
            for (int j = 0; j < 8; j++) wdata[j] = 8'($urandom);
            fi = $urandom_range(0, 3) - 1;
            ab = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 8 * (n + 1) - 1) : -1;
            ns = {16'($urandom), 32'($urandom)};
            frame({1'($urandom), 1'($urandom), ra}, n, ab, fi, ns);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/adxl345_spi_responder.md
# adxl345_spi_responder

SPI slave that emulates the ADXL345 register interface at the far end of the accelerometer link. It is used as an on-chip loopback/bench target for the SPI master control path, and as a sensor model fed by synthetic axis samples. It decodes the command byte, serves single- or multi-byte register reads, and commits register writes. It also exposes the writable configuration registers to the surrounding logic.

## Interface
Parameters:
- DEVID_VAL, 8'hE5, value returned from register 0x00
- BW_RATE_RST, 8'h0A, reset value of BW_RATE (0x2C)

Ports:
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- spi_clk  in  1  SPI clock from master (mode 3, idles high); asynchronous to clk
- CS  in  1  chip select, active low; asynchronous to clk
- MOSI  in  1  serial data from master
- MISO  out  1  serial data to master
- axis_x, axis_y, axis_z  in  16 each  two's-complement samples; byte 0 = [7:0], byte 1 = [15:8]
- sample_valid  in  1  one-cycle strobe; capture axis_* into the live sample registers
- power_ctl  out  8  POWER_CTL (0x2D) contents
- bw_rate  out  8  BW_RATE (0x2C) contents
- data_format  out  8  DATA_FORMAT (0x31) contents
- wr_strobe  out  1  one-cycle pulse on each committed write
- wr_addr  out  6  address of the last committed write
- busy  out  1  high while a frame is active (synchronized CS low)

## Operation
- spi_clk, CS and MOSI each pass through a 2-flop synchronizer, followed by an edge detector: sclk_rise, sclk_fall, cs_fall, cs_rise.
- FSM states: IDLE, CMD, RD, WR.
- IDLE -> CMD on cs_fall. bit_cnt is cleared.
- CMD: shift in MOSI MSB-first on each sclk_rise. After the 8th bit:
  - bit7 = R/W (1 = read), bit6 = MB, bits5:0 = start address.
  - If read, go to RD and load the shift register with reg[addr]. If write, go to WR.
- RD: on each sclk_fall, MISO is driven from the shift register MSB. On each sclk_rise, bit_cnt advances. After the 8th rise:
  - If MB, addr increments; otherwise addr holds.
  - The shift register reloads with reg[addr].
- WR: MOSI is shifted in on sclk_rise. After the 8th rise:
  - If addr is 0x2C, 0x2D or 0x31, the byte is committed to that register, wr_strobe pulses and wr_addr is updated.
  - Writes to any other address are ignored, with no strobe.
  - addr then increments if MB.
- Address arithmetic is 6-bit; 0x3F + 1 wraps to 0x00.
- Read map:
  - 0x00 returns DEVID_VAL.
  - 0x2C, 0x2D and 0x31 return the register contents.
  - 0x32–0x37 return X0, X1, Y0, Y1, Z0, Z1.
  - All other addresses return 0x00.
- cs_rise in any state returns the FSM to IDLE. A partial byte is discarded and no write is committed. MISO returns to 0.
- A sample_valid arriving at the same time as any SPI event updates only the live sample registers. It never corrupts the shift register.

## Timing
- Reset values: MISO 0, power_ctl 0x00, bw_rate BW_RATE_RST, data_format 0x00, wr_strobe 0, wr_addr 0, busy 0, FSM IDLE.
- Latency from a pin edge to the internal event is 3 clk: 2 synchronizer stages plus 1 detect stage.
- MISO updates 4 clk after the spi_clk falling edge at the pin.
- Write commit and wr_strobe occur 4 clk after the 8th data-bit rising edge.
- The master must hold each spi_clk half-period at ≥ 6 clk. Faster clocks are unsupported.
- The first read data bit (bit7) appears on the falling edge that follows the 8th command rising edge.
- busy rises 3 clk after CS falls and drops 3 clk after CS rises.

## Configuration
- ADXL345_RESP_SNAPSHOT_EN:
  - Defined: on cs_fall, the live samples for all six axis bytes are copied into a snapshot bank, and 0x32–0x37 read from that snapshot. A multi-byte read is therefore coherent even if sample_valid fires mid-frame.
  - Undefined: 0x32–0x37 read the live registers at each byte-load instant. The snapshot bank is not built.

## Structure
- Package adxl345_pkg holds:
  - the address constants: ADDR_DEVID, ADDR_BW_RATE, ADDR_POWER_CTL, ADDR_DATA_FORMAT, ADDR_DATAX0..ADDR_DATAZ1
  - the reset values
  - the FSM state enum
  - the command-bit positions (RW_BIT = 7, MB_BIT = 6)
- One sub-module, spi_edge_sync: a 2-flop synchronizer plus edge detector. It is instantiated for spi_clk and CS; MOSI uses only its synchronized output.

## Test plan
- Read 0x00 (command 0x80, one byte) -> MISO byte 0xE5; no wr_strobe.
- Write 0x2D = 0x08 (command 0x2D, 0x08) -> power_ctl = 0x08; wr_strobe one pulse; wr_addr = 0x2D.
- axis_x = 0x1234, axis_y = 0xFF80, axis_z = 0x0100; multi-byte read with command 0xF2, 6 bytes -> 34 12 80 FF 00 01.
- With SNAPSHOT_EN: sample_valid fires after byte 2 with new values -> the remaining bytes still return the old values. Without SNAPSHOT_EN -> the remaining bytes return the new values.
- Write to 0x31 with CS raised after 5 data bits -> data_format unchanged, no strobe; the next frame decodes normally.
- Write to 0x00 = 0x55 -> ignored, DEVID still reads 0xE5. MB read starting at 0x3F, 2 bytes -> 0x00 then 0xE5 (wrap to 0x00).
